// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for a single-cycle core.
// Decodes the processor address into a word RAM and a 4-word MMIO block
// (LED, synchronized switches, cycle counter, status). Reads are
// combinational; writes land on the rising clock edge.
module data_mem_responder #(
    parameter int             N         = 32,
    parameter int             DEPTH     = 256,
    parameter logic [N-1:0]   MMIO_BASE = 32'h0000_0400,
    parameter int             IO_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    address,
    input  logic [N-1:0]    write_data,
    input  logic            mem_write,
    output logic [N-1:0]    read_data,
    input  logic [IO_W-1:0] switches_in,
    output logic [IO_W-1:0] leds,
    output logic            err
);

    localparam int           AW        = $clog2(DEPTH);
    localparam logic [N-1:0] RAM_BYTES = N'(DEPTH * 4);
    localparam logic [N-1:0] MMIO_END  = MMIO_BASE + N'(16);

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_SWITCH = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // Word RAM; deliberately not reset so contents survive a reset pulse.
    logic [N-1:0]    r_ram [DEPTH];

    logic [IO_W-1:0] r_leds;
    logic [IO_W-1:0] r_sw_meta;
    logic [IO_W-1:0] r_sw_sync;
    logic [31:0]     r_cycle;
    logic            r_err;

    logic            w_aligned;
    logic            w_ram_hit;
    logic            w_mmio_hit;
    logic [1:0]      w_mmio_off;
    logic [AW-1:0]   w_ram_idx;
    logic            w_valid;
    logic            w_wr_ram;
    logic            w_wr_mmio;
    logic            w_err_set;
    logic            w_err_clr;
    logic [N-1:0]    w_read_data;

    assign w_aligned  = (address[1:0] == 2'b00);
    assign w_ram_hit  = (address < RAM_BYTES);
    assign w_mmio_hit = (address >= MMIO_BASE) && (address < MMIO_END);
    assign w_mmio_off = 2'((address - MMIO_BASE) >> 2);
    assign w_ram_idx  = address[AW+1:2];
    assign w_valid    = w_aligned && (w_ram_hit || w_mmio_hit);

    assign w_wr_ram   = mem_write && w_valid && w_ram_hit;
    assign w_wr_mmio  = mem_write && w_valid && w_mmio_hit;
    // A store that is unmapped or misaligned is discarded and flagged.
    assign w_err_set  = mem_write && !w_valid;
    assign w_err_clr  = w_wr_mmio && (w_mmio_off == OFF_STATUS) && write_data[0];

    assign leds       = r_leds;
    assign err        = r_err;
    assign read_data  = w_read_data;

    // RAM store port; no write is accepted while reset is held.
    always_ff @(posedge clk) begin
        if (rst && w_wr_ram) begin
            r_ram[w_ram_idx] <= write_data;
        end
    end

    // LED register: loaded by a store to the LED offset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_leds <= {IO_W{1'b0}};
        end else if (w_wr_mmio && (w_mmio_off == OFF_LED)) begin
            r_leds <= write_data[IO_W-1:0];
        end else begin
            r_leds <= r_leds;
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta <= {IO_W{1'b0}};
            r_sw_sync <= {IO_W{1'b0}};
        end else begin
            r_sw_meta <= switches_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Free-running cycle counter; a store overrides the increment for that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= 32'h0000_0000;
        end else if (w_wr_mmio && (w_mmio_off == OFF_CYCLE)) begin
            r_cycle <= 32'(write_data);
        end else begin
            r_cycle <= r_cycle + 32'h0000_0001;
        end
    end

    // Sticky error flag: set wins over the write-one-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    // Combinational read mux; anything not a valid aligned hit reads zero.
    always_comb begin
        w_read_data = {N{1'b0}};
        if (!rst) begin
            w_read_data = {N{1'b0}};
        end else if (!w_aligned) begin
            w_read_data = {N{1'b0}};
        end else if (w_ram_hit) begin
            w_read_data = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_mmio_off)
                OFF_LED:    w_read_data = N'(r_leds);
                OFF_SWITCH: w_read_data = N'(r_sw_sync);
                OFF_CYCLE:  w_read_data = N'(r_cycle);
                OFF_STATUS: w_read_data = N'(r_err);
                default:    w_read_data = {N{1'b0}};
            endcase
        end else begin
            w_read_data = {N{1'b0}};
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a behavioural memory-map model
// predicts read_data/leds/err for every cycle; a monitor compares them
// on the falling clock edge.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic [31:0] read_data;
    logic [7:0]  switches_in;
    logic [7:0]  leds;
    logic        err;

    data_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .write_data  (write_data),
        .mem_write   (mem_write),
        .read_data   (read_data),
        .switches_in (switches_in),
        .leds        (leds),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [7:0]  leds;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state
    logic [31:0] mem_m [256];
    logic [7:0]  leds_m;
    logic [31:0] cyc_m;
    logic        err_m;
    logic [7:0]  sw1_m;
    logic [7:0]  sw2_m;

    function automatic logic is_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'h400 || (a >= 32'h400 && a < 32'h410));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!rst || !is_valid(a)) return 32'h0;
        if (a < 32'h400) return mem_m[a[9:2]];
        case (a - 32'h400)
            32'h0:   return {24'h0, leds_m};
            32'h4:   return {24'h0, sw2_m};
            32'h8:   return cyc_m;
            32'hC:   return {31'h0, err_m};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        leds_m = 8'h00;
        cyc_m  = 32'h0;
        err_m  = 1'b0;
        sw1_m  = 8'h00;
        sw2_m  = 8'h00;
    endtask

    // Effect of one rising edge on the architectural state
    task automatic model_edge(input logic [31:0] a, input logic [31:0] wd,
                              input logic we, input logic [7:0] sw);
        logic [31:0] next_cyc;
        next_cyc = cyc_m + 32'h1;
        if (we && !is_valid(a)) begin
            err_m = 1'b1;
        end else if (we) begin
            if (a < 32'h400) mem_m[a[9:2]] = wd;
            else if (a == 32'h400) leds_m = wd[7:0];
            else if (a == 32'h408) next_cyc = wd;
            else if (a == 32'h40C && wd[0]) err_m = 1'b0;
        end
        cyc_m = next_cyc;
        sw2_m = sw1_m;
        sw1_m = sw;
    endtask

    task automatic push_exp(input string nm, input logic [31:0] a);
        exp_t e;
        e.name = nm;
        e.rd   = model_read(a);
        e.leds = leds_m;
        e.err  = err_m;
        q.push_back(e);
    endtask

    // One bus cycle: drive, predict, then advance model at the edge
    task automatic step(input string nm, input logic [31:0] a, input logic [31:0] wd,
                        input logic we);
        address    = a;
        write_data = wd;
        mem_write  = we;
        push_exp(nm, a);
        @(posedge clk);
        model_edge(a, wd, we, switches_in);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest prediction
    exp_t m_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            checks += 3;
            if (read_data === m_e.rd) passes++;
            else $display("FAIL %s read_data got %h want %h", m_e.name, read_data, m_e.rd);
            if (leds === m_e.leds) passes++;
            else $display("FAIL %s leds got %h want %h", m_e.name, leds, m_e.leds);
            if (err === m_e.err) passes++;
            else $display("FAIL %s err got %b want %b", m_e.name, err, m_e.err);
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            2:       return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            3:       return 32'h400 + 32'(4 * $urandom_range(0, 3));
            4:       return 32'h400 + 32'($urandom_range(0, 15));
            default: return 32'h410 + 32'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    initial begin
        rst         = 1'b1;
        address     = 32'h0;
        write_data  = 32'h0;
        mem_write   = 1'b0;
        switches_in = 8'h00;
        #2 rst = 1'b0;
        model_reset();
        push_exp("reset", 32'h408);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        model_edge(32'h408, 32'h0, 1'b0, switches_in);
        #1;

        // Give every RAM word a known value
        for (int i = 0; i < 256; i++) begin
            step("ram_init", 32'(i * 4), 32'hA5A5_0000 ^ 32'(i * 32'h0101), 1'b1);
        end

        // RAM round trip
        step("ram_wr_old", 32'h10, 32'hDEAD_BEEF, 1'b1);
        step("ram_rd_new", 32'h10, 32'h0, 1'b0);
        step("ram_last_wr", 32'h3FC, 32'h1234_5678, 1'b1);
        step("ram_last_rd", 32'h3FC, 32'h0, 1'b0);

        // LED
        step("led_wr", 32'h400, 32'h0000_01A5, 1'b1);
        step("led_rd", 32'h400, 32'h0, 1'b0);

        // Switch synchronizer
        step("sw_settle", 32'h404, 32'h0, 1'b0);
        step("sw_settle", 32'h404, 32'h0, 1'b0);
        switches_in = 8'h3C;
        step("sw_edge0", 32'h404, 32'h0, 1'b0);
        step("sw_edge1", 32'h404, 32'h0, 1'b0);
        step("sw_edge2", 32'h404, 32'h0, 1'b0);
        step("sw_wr_ign", 32'h404, 32'hFFFF_FFFF, 1'b1);
        step("sw_no_err", 32'h404, 32'h0, 1'b0);

        // Cycle counter wrap and load
        step("cyc_wr", 32'h408, 32'hFFFF_FFFE, 1'b1);
        step("cyc_fe", 32'h408, 32'h0, 1'b0);
        step("cyc_ff", 32'h408, 32'h0, 1'b0);
        step("cyc_wrap", 32'h408, 32'h0, 1'b0);
        step("cyc_load", 32'h408, 32'h1234_5678, 1'b1);
        step("cyc_loaded", 32'h408, 32'h0, 1'b0);

        // Errors
        step("err_unmap_wr", 32'h2000, 32'h5555_5555, 1'b1);
        step("err_ram_spot", 32'h10, 32'h0, 1'b0);
        step("err_led_spot", 32'h400, 32'h0, 1'b0);
        step("err_misalign", 32'h11, 32'h7777_7777, 1'b1);
        step("err_rd_unmap", 32'h2000, 32'h0, 1'b0);
        step("err_w0_noop", 32'h40C, 32'h0, 1'b1);
        step("err_status", 32'h40C, 32'h0, 1'b0);
        step("err_w1c", 32'h40C, 32'h1, 1'b1);
        step("err_cleared", 32'h40C, 32'h0, 1'b0);
        step("err_rd_nset", 32'h2000, 32'h0, 1'b0);
        step("err_ram_misal_rd", 32'h12, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) switches_in = 8'($urandom);
            step("rand", rand_addr(), $urandom, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges
        step("pre_rst_led", 32'h400, 32'h0000_00FF, 1'b1);
        step("pre_rst_ram", 32'h20, 32'hCAFE_F00D, 1'b1);
        step("pre_rst_err", 32'h2000, 32'h0, 1'b1);
        step("pre_rst_chk", 32'h408, 32'h0, 1'b0);
        address   = 32'h400;
        mem_write = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        push_exp("async_rst", 32'h400);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        model_edge(32'h400, 32'h0, 1'b0, switches_in);
        #1;
        step("post_rst_cyc", 32'h408, 32'h0, 1'b0);
        step("post_rst_ram", 32'h20, 32'h0, 1'b0);
        step("post_rst_led", 32'h400, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain left %0d want 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the processor's data-memory interface. It accepts the processor's address, write data and write strobe, and returns read data in the same cycle, as the single-cycle core requires. It decodes the address into a word RAM and a small MMIO register block: LED output, synchronized switch input, cycle counter and status. It sits beside the processor in the top level and drives the processor's read_data input.

Parameters:
N, 32, data/address width in bits
DEPTH, 256, RAM depth in words; RAM occupies bytes 0 .. DEPTH*4-1
MMIO_BASE, 32'h0000_0400, byte base address of the 4-word MMIO block; must be >= DEPTH*4
IO_W, 8, LED/switch width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
address  input  N  byte address from processor (alu_result)
write_data  input  N  store data from processor
mem_write  input  1  write strobe, sampled at rising clk
read_data  output  N  combinational read data to processor
switches_in  input  IO_W  asynchronous external switches
leds  output  IO_W  registered LED drive
err  output  1  sticky access-error flag (mirror of STATUS[0])

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release at clk): leds=0, cycle counter=0, switch synchronizer flops=0, err=0, read_data=0 while rst=0. RAM contents are not cleared; they hold their values through reset.
- Decode: RAM hit when address < DEPTH*4. MMIO hit when MMIO_BASE <= address < MMIO_BASE+16. Anything else is unmapped.
- Misalignment: address[1:0] != 0 is misaligned, whatever the region.
- Reads: combinational, with no read strobe; read_data follows address within the same cycle.
  - RAM: RAM[address>>2].
  - MMIO: the register value, zero-extended.
  - Unmapped or misaligned: 0.
  - Reads never set err, because the processor drives address every cycle.
- Writes: take effect at the rising edge when mem_write=1, the address is aligned and the region is mapped.
  - A read of the same address in the cycle of the write returns the old value; the new value is visible from the next cycle.
- MMIO map (byte offset from MMIO_BASE):
  - 0x0 LED (RW): writes load write_data[IO_W-1:0] into leds; reads return leds.
  - 0x4 SWITCH (RO): two-flop synchronizer on switches_in. A change is visible on read_data 2 rising edges after it is applied. Writes are ignored and do not set err.
  - 0x8 CYCLE (RW): 32-bit free-running counter, +1 every edge, wraps FFFF_FFFF -> 0. A write loads write_data at that edge; the load overrides the increment for that edge, and incrementing resumes on the next edge.
  - 0xC STATUS: bit0 = err, other bits read 0. Writing 1 to bit0 clears err (W1C); writing 0 has no effect.
- Error set: err becomes 1 at the edge on which mem_write=1 and the address is unmapped or misaligned. That write is discarded.
- Simultaneous set and clear: a set has priority over a W1C clear in the same cycle. A W1C targets a valid address, so a same-cycle set only arises in multi-cause scenarios; the implementation must still encode set-priority.
- Reset during operation: a reset asserted in a write cycle discards the write to MMIO state; all MMIO registers and err go to their reset values immediately.

Test Plan:
- RAM round trip: write 0xDEADBEEF to 0x10.
  - Same-cycle read returns the old value.
  - Next-cycle read returns 0xDEADBEEF.
  - Read 0x3FC (last word) after writing 0x12345678 returns 0x12345678.
- LED: write 0x1A5 to 0x400 -> leds=0xA5 after the edge, and a read of 0x400 returns 0x000000A5.
- Switch synchronizer: switches_in 0x00->0x3C -> a read of 0x404 returns 0x00 after 1 edge and 0x3C after 2 edges. A write to 0x404 leaves err=0.
- Cycle counter:
  - Write 0xFFFFFFFE to 0x408 -> reads give 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 on consecutive cycles.
  - A write colliding with an increment loads exactly the written value.
- Errors:
  - Write to 0x2000 -> err=1; a RAM/MMIO spot check shows nothing changed.
  - Write to 0x11 -> err stays 1.
  - Write 0x1 to 0x40C -> err=0 next cycle.
  - A read of 0x2000 returns 0 and does not set err.
- Async reset mid-run: with leds=0xFF and the counter running, pull rst low between edges -> leds, counter and err are 0 immediately without a clock edge. A RAM word written earlier still reads back after release.
